request_encoder_4x2: RTL and testbench

Registered 4-to-2 priority encoder with event capture and a valid/ready output handshake. It is the receiving end of the 2x4 decoder's active-low one-hot bus. It detects falling edges on the active-low `D` lines and queues each as a pending request. It then reports pending requests one at a time as a 2-bit index `{A,B}`, matching the decoder's `{A,B}` → `D[i]` mapping. It sits wherever decoded strobes must be converted back to an index for a downstream consumer.

---
 rtl/encoder_pkg.sv | 19 +
 rtl/priority_pick_4.sv | 24 ++
 rtl/request_encoder_4x2.sv | 100 ++++++++++
 tb/tb_request_encoder_4x2.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the 4-to-2 request encoder: widths, FSM state type
// and the index-to-one-hot helper used to form the service mask.
package encoder_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = $clog2(N_REQ);

    // ENC_IDLE: nothing presented. ENC_HOLD: {A,B} valid, waiting for ready.
    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_HOLD = 1'b1
    } enc_state_t;

    // One-hot mask with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        onehot_of = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_pick_4.sv
// Combinational highest-index-first priority pick over four request bits.
module priority_pick_4
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Highest set bit wins; idx is 0 when nothing is set.
    always_comb begin
        idx = '0;
        any = |vec;
        if (vec[3])
            idx = 2'd3;
        else if (vec[2])
            idx = 2'd2;
        else if (vec[1])
            idx = 2'd1;
        else
            idx = 2'd0;
    end

endmodule

// File: rtl/request_encoder_4x2.sv
// Registered 4-to-2 priority encoder. Falling edges on the active-low D bus
// are queued as pending bits and reported one at a time as {A,B} through a
// valid/ready handshake. All outputs come straight from flops.
module request_encoder_4x2
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] D,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             A,
    output logic             B,
    output logic [N_REQ-1:0] pending,
    output logic             overrun
);

    logic [N_REQ-1:0] d_q;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic             overrun_q;
    logic             overrun_d;
    enc_state_t       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;

    logic [N_REQ-1:0] evt;
    logic [N_REQ-1:0] served;
    logic [N_REQ-1:0] rem;
    logic [N_REQ-1:0] pick_vec;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // Event, service and next-pending terms for the current cycle.
    always_comb begin
        evt       = d_q & ~D & {N_REQ{enable}};
        served    = (valid_q && out_ready) ? onehot_of(idx_q) : '0;
        rem       = pending_q & ~served;
        // An event on a bit being served in the same cycle keeps it set.
        pending_d = rem | evt;
        overrun_d = overrun_q | (|(evt & pending_q & ~served));
        // Same-cycle events are deliberately excluded from the next pick.
        pick_vec  = (state_q == ENC_IDLE) ? pending_q : rem;
    end

    priority_pick_4 u_pick (
        .vec (pick_vec),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Edge detect, pending queue, sticky overrun and presentation FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q       <= '1;
            pending_q <= '0;
            overrun_q <= 1'b0;
            state_q   <= ENC_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            d_q       <= D;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                ENC_IDLE: begin
                    if (pick_any) begin
                        state_q <= ENC_HOLD;
                        valid_q <= 1'b1;
                        idx_q   <= pick_idx;
                    end
                end
                ENC_HOLD: begin
                    // Without ready the presented index is frozen, even if a
                    // higher-priority line becomes pending.
                    if (out_ready) begin
                        if (pick_any) begin
                            idx_q <= pick_idx;
                        end else begin
                            state_q <= ENC_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ENC_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign A         = idx_q[1];
    assign B         = idx_q[0];
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_request_encoder_4x2.sv
// Bench for request_encoder_4x2: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the request queue.
module tb_request_encoder_4x2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] D;
    logic       out_ready;
    logic       out_valid;
    logic       A;
    logic       B;
    logic [3:0] pending;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit [3:0] m_prev_d;
    bit [3:0] m_pend;
    bit       m_ovr;
    int       m_shown;      // presented index, -1 when nothing is presented
    bit [1:0] m_ab;
    int       dut_xfer[4];  // transfers observed on the DUT outputs, per index

    request_encoder_4x2 dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .D         (D),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .A         (A),
        .B         (B),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic int highest(input bit [3:0] v);
        for (int i = 3; i >= 0; i--)
            if (v[i]) return i;
        return -1;
    endfunction

    // Applies one rising edge worth of the request-queue rules to the model.
    task automatic model_edge();
        bit [3:0] fell;
        bit [3:0] left;
        int       taken;
        if (reset) begin
            m_prev_d = 4'hF;
            m_pend   = 4'h0;
            m_ovr    = 1'b0;
            m_shown  = -1;
            m_ab     = 2'd0;
            return;
        end
        fell  = 4'h0;
        for (int i = 0; i < 4; i++)
            fell[i] = enable && m_prev_d[i] && !D[i];
        taken = (m_shown >= 0 && out_ready) ? m_shown : -1;
        left  = m_pend;
        if (taken >= 0) left[taken] = 1'b0;
        for (int i = 0; i < 4; i++)
            if (fell[i] && m_pend[i] && i != taken) m_ovr = 1'b1;
        if (m_shown < 0) begin
            if (m_pend != 0) m_shown = highest(m_pend);
        end else if (out_ready) begin
            m_shown = (left != 0) ? highest(left) : -1;
        end
        if (m_shown >= 0) m_ab = 2'(m_shown);
        m_pend   = left | fell;
        m_prev_d = D;
    endtask

    // One clock: record a completed handshake, advance model, settle to negedge.
    task automatic tick();
        if (!reset && out_valid && out_ready) dut_xfer[{A, B}]++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_xfer();
        for (int i = 0; i < 4; i++) dut_xfer[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; D = 4'hF; enable = 1'b1; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; D = 4'hF; enable = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_tests++; if ({A, B} !== 2'b00) begin n_fail++; $display("FAIL reset_ab: got %b want 00", {A, B}); end
        reset = 1'b0;
        repeat (3) tick();
        n_tests++; if ({out_valid, pending} !== 5'b0) begin n_fail++; $display("FAIL idle_quiet: got %b want 00000", {out_valid, pending}); end
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1; out_ready = 1'b1; D = 4'b1011;
        tick();
        n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_pend: got %b want 0100", pending); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        D = 4'b1111;
        tick();
        n_tests++; if ({out_valid, A, B} !== 3'b110) begin n_fail++; $display("FAIL single_present: got %b want 110", {out_valid, A, B}); end
        tick();
        n_tests++; if ({out_valid, pending} !== 5'b0) begin n_fail++; $display("FAIL single_done: got %b want 00000", {out_valid, pending}); end
    endtask

    task automatic test_priority_hold();
        bit [1:0] seq[3];
        seq[0] = 2'b11; seq[1] = 2'b10; seq[2] = 2'b00;
        do_reset();
        enable = 1'b1; out_ready = 1'b0; D = 4'b0110;
        tick();
        n_tests++; if (pending !== 4'b1001) begin n_fail++; $display("FAIL prio_pend: got %b want 1001", pending); end
        tick();
        n_tests++; if ({out_valid, A, B} !== 3'b111) begin n_fail++; $display("FAIL prio_present: got %b want 111", {out_valid, A, B}); end
        D = 4'b0010;
        repeat (2) tick();
        n_tests++; if (pending !== 4'b1101) begin n_fail++; $display("FAIL prio_pend2: got %b want 1101", pending); end
        n_tests++; if ({out_valid, A, B} !== 3'b111) begin n_fail++; $display("FAIL prio_hold: got %b want 111", {out_valid, A, B}); end
        out_ready = 1'b1; D = 4'b1111;
        for (int k = 1; k < 3; k++) begin
            tick();
            n_tests++; if ({out_valid, A, B} !== {1'b1, seq[k]}) begin n_fail++; $display("FAIL prio_seq%0d: got %b want %b", k, {out_valid, A, B}, {1'b1, seq[k]}); end
        end
        tick();
        n_tests++; if ({out_valid, pending} !== 5'b0) begin n_fail++; $display("FAIL prio_drain: got %b want 00000", {out_valid, pending}); end
    endtask

    task automatic test_disabled();
        do_reset();
        enable = 1'b0; out_ready = 1'b1; D = 4'b1110;
        repeat (2) tick();
        n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL dis_capture: got %b want 0000", pending); end
        enable = 1'b1;
        tick();
        n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL dis_reenable: got %b want 0000", pending); end
        D = 4'b1111;
        tick();
        D = 4'b1110;
        tick();
        n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL dis_refall: got %b want 0001", pending); end
        D = 4'b1111;
        repeat (2) tick();
        n_tests++; if ({out_valid, pending} !== 5'b0) begin n_fail++; $display("FAIL dis_drain: got %b want 00000", {out_valid, pending}); end
    endtask

    task automatic test_overrun();
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        D = 4'b1101; tick();
        D = 4'b1111; tick();
        D = 4'b1101; tick();
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ovr_pend: got %b want 0010", pending); end
        D = 4'b1111;
        clear_xfer();
        out_ready = 1'b1;
        repeat (4) tick();
        n_tests++; if (dut_xfer[1] !== 1) begin n_fail++; $display("FAIL ovr_once: got %0d transfers want 1", dut_xfer[1]); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_collision_reset();
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        D = 4'b1101; tick();
        D = 4'b1111; tick();
        n_tests++; if ({out_valid, A, B} !== 3'b101) begin n_fail++; $display("FAIL coll_present: got %b want 101", {out_valid, A, B}); end
        out_ready = 1'b1; D = 4'b1101;
        tick();
        n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL coll_keep: got %b want 0010", pending); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL coll_no_ovr: got %b want 0", overrun); end
        tick();
        n_tests++; if ({out_valid, A, B} !== 3'b101) begin n_fail++; $display("FAIL coll_again: got %b want 101", {out_valid, A, B}); end
        out_ready = 1'b0; reset = 1'b1; D = 4'b1111;
        tick();
        reset = 1'b0;
        n_tests++; if ({out_valid, A, B, pending, overrun} !== 8'b0) begin n_fail++; $display("FAIL mid_reset: got %b want 00000000", {out_valid, A, B, pending, overrun}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) D[i] = ($urandom_range(99) >= 30);
            enable    = ($urandom_range(99) < 80);
            out_ready = ($urandom_range(99) < 50);
            reset     = ($urandom_range(199) == 0);
            tick();
            n_tests++; if (out_valid !== (m_shown >= 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, (m_shown >= 0)); end
            n_tests++; if ({A, B} !== m_ab) begin n_fail++; $display("FAIL rnd_ab c%0d: got %b want %b", c, {A, B}, m_ab); end
            n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend c%0d: got %b want %b", c, pending, m_pend); end
            n_tests++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_ovr c%0d: got %b want %b", c, overrun, m_ovr); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; D = 4'hF; out_ready = 1'b0;
        m_prev_d = 4'hF; m_pend = 4'h0; m_ovr = 1'b0; m_shown = -1; m_ab = 2'd0;
        clear_xfer();
        @(negedge clk);
        test_reset();
        test_single();
        test_priority_hold();
        test_disabled();
        test_overrun();
        test_collision_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
